led_pattern_rm: RTL and testbench



---
 rtl/led_rm_pkg.sv | 26 ++
 rtl/rm_tick_gen.sv | 28 ++
 rtl/led_pattern_rm.sv | 103 ++++++++++
 tb/tb_led_pattern_rm.sv | 124 ++++++++++++
 4 files changed

// File: rtl/led_rm_pkg.sv
// Shared types and constants for the LED pattern reconfigurable module.
// Holds the walker/counter state enums and the pattern turn-around values.
package led_rm_pkg;

    typedef enum logic {
        W_LEFT  = 1'b0,
        W_RIGHT = 1'b1
    } walk_state_t;

    typedef enum logic {
        C_UP   = 1'b0,
        C_DOWN = 1'b1
    } cnt_state_t;

    localparam logic [3:0] UPPER_RST   = 4'b0001;
    localparam logic [3:0] LOWER_RST   = 4'h0;
    localparam logic [3:0] WALK_TURN_L = 4'b0100;
    localparam logic [3:0] WALK_TURN_R = 4'b0010;
    localparam logic [3:0] CNT_TOP     = 4'hE;
    localparam logic [3:0] CNT_BOT     = 4'h1;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/rm_tick_gen.sv
// Prescaler: counts 0..PRESCALE_MAX and pulses tick for one cycle at the
// terminal count. PRESCALE_MAX=0 leaves tick permanently high.
module rm_tick_gen #(
    parameter int PRESCALE_W   = 27,
    parameter int PRESCALE_MAX = 99_999_999
) (
    input  logic gclk,
    input  logic rst,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] MAX_V = PRESCALE_W'(PRESCALE_MAX);

    logic [PRESCALE_W-1:0] presc;

    assign tick = (presc == MAX_V);

    always_ff @(posedge gclk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_rm.sv
// Reconfigurable partition contents: bouncing one-hot walker on the upper
// nibble and an up/down triangle counter on the lower nibble, both stepping on tick.
module led_pattern_rm
    import led_rm_pkg::*;
#(
    parameter int PRESCALE_W   = 27,
    parameter int PRESCALE_MAX = 99_999_999
) (
    input  logic       gclk,
    input  logic       rst,
    output logic [3:0] upper,
    output logic [3:0] lower
);

    logic        tick;
    walk_state_t walk_state, walk_next;
    cnt_state_t  cnt_state, cnt_next;
    logic [3:0]  upper_next, lower_next;

    rm_tick_gen #(
        .PRESCALE_W  (PRESCALE_W),
        .PRESCALE_MAX(PRESCALE_MAX)
    ) u_tick (
        .gclk(gclk),
        .rst (rst),
        .tick(tick)
    );

    always_ff @(posedge gclk) begin
        if (rst) begin
            walk_state <= W_LEFT;
            upper      <= UPPER_RST;
            cnt_state  <= C_UP;
            lower      <= LOWER_RST;
        end else begin
            walk_state <= walk_next;
            upper      <= upper_next;
            cnt_state  <= cnt_next;
            lower      <= lower_next;
        end
    end

    // A corrupted (non-one-hot) walker restarts from the reset pattern.
    always_comb begin
        walk_next  = walk_state;
        upper_next = upper;
        if (tick) begin
            if (!is_one_hot(upper)) begin
                walk_next  = W_LEFT;
                upper_next = UPPER_RST;
            end else begin
                case (walk_state)
                    W_LEFT: begin
                        upper_next = upper << 1;
                        if (upper == WALK_TURN_L) walk_next = W_RIGHT;
                    end
                    W_RIGHT: begin
                        upper_next = upper >> 1;
                        if (upper == WALK_TURN_R) walk_next = W_LEFT;
                    end
                    default: begin
                        walk_next  = W_LEFT;
                        upper_next = UPPER_RST;
                    end
                endcase
            end
        end
    end

    // The extreme-value guards keep the count from ever wrapping, even if
    // state and count disagree after an upset.
    always_comb begin
        cnt_next   = cnt_state;
        lower_next = lower;
        if (tick) begin
            case (cnt_state)
                C_UP: begin
                    if (lower == 4'hF) begin
                        lower_next = CNT_TOP;
                        cnt_next   = C_DOWN;
                    end else begin
                        lower_next = lower + 4'h1;
                        if (lower == CNT_TOP) cnt_next = C_DOWN;
                    end
                end
                C_DOWN: begin
                    if (lower == 4'h0) begin
                        lower_next = CNT_BOT;
                        cnt_next   = C_UP;
                    end else begin
                        lower_next = lower - 4'h1;
                        if (lower == CNT_BOT) cnt_next = C_UP;
                    end
                end
                default: begin
                    cnt_next   = C_UP;
                    lower_next = LOWER_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_rm.sv
// Bench for led_pattern_rm: a slow-prescale and a PRESCALE_MAX=0 instance
// share rst; a tick-count model feeds expected queues drained by a monitor.
module tb_led_pattern_rm;

    logic       gclk;
    logic       rst;
    logic [3:0] upper3, lower3;
    logic [3:0] upper0, lower0;

    led_pattern_rm #(.PRESCALE_W(4), .PRESCALE_MAX(3)) dut3 (
        .gclk (gclk),
        .rst  (rst),
        .upper(upper3),
        .lower(lower3)
    );

    led_pattern_rm #(.PRESCALE_W(4), .PRESCALE_MAX(0)) dut0 (
        .gclk (gclk),
        .rst  (rst),
        .upper(upper0),
        .lower(lower0)
    );

    // clock / reset
    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    // scoreboard state
    logic [7:0] exp3_q[$];
    logic [7:0] exp0_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e3    = 0;
    int e0    = 0;

    // Pattern after k steps: walker bounces over bit positions 0..3 with
    // period 6, counter is a 0..15..0 triangle with period 30.
    function automatic logic [7:0] model(input int k);
        int p, pos, c, l;
        logic [3:0] u;
        p   = k % 6;
        pos = (p <= 3) ? p : 6 - p;
        c   = k % 30;
        l   = (c <= 15) ? c : 30 - c;
        u   = 4'b0001 << pos;
        return {u, 4'(l)};
    endfunction

    // driver: apply rst for one edge and queue the state the DUTs must hold after it
    task automatic drive(input logic r);
        rst = r;
        @(posedge gclk);
        cyc++;
        if (r) begin
            e3 = 0;
            e0 = 0;
        end else begin
            e3++;
            e0++;
        end
        exp3_q.push_back(model(e3 / 4));
        exp0_q.push_back(model(e0));
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, req);
        end
    endtask

    // monitor: one registered output set per edge, compared on the falling edge
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge gclk);
            if (exp3_q.size() > 0) begin
                e = exp3_q.pop_front();
                check("upper_p3", upper3, e[7:4]);
                check("lower_p3", lower3, e[3:0]);
            end
            if (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                check("upper_p0", upper0, e[7:4]);
                check("lower_p0", lower0, e[3:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        // reset held, then a long run covering walker bounce and counter turnaround
        repeat (3) drive(1'b1);
        repeat (140) drive(1'b0);
        // reset two cycles after tick 10
        drive(1'b1);
        repeat (42) drive(1'b0);
        drive(1'b1);
        repeat (12) drive(1'b0);
        // reset on the edge that would carry a tick
        repeat (7) drive(1'b0);
        drive(1'b1);
        repeat (10) drive(1'b0);
        // random reset pulses
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 59) == 0);
        end
        repeat (2) @(negedge gclk);
        #1;
        if (exp3_q.size() != 0 || exp0_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", exp3_q.size() + exp0_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
